cdma_engine: RTL and testbench

- Single-channel byte DMA engine. It moves a block of bytes between the system Wishbone bus and the on-chip scratchpad memory.
- It is a Wishbone master on the bus side. On the scratchpad side it drives the cDMA port (dma_req / dmaaddr / we / write data, registered read data).
- The CPU-side control block supplies a descriptor and a start pulse, then observes busy, done and err.

---
 rtl/cdma_pkg.sv | 26 ++
 rtl/cdma_if.sv | 55 +++++
 rtl/cdma_wb_timer.sv | 37 +++
 rtl/cdma_engine.sv | 182 ++++++++++++++++++
 tb/tb_cdma_engine.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdma_pkg.sv
// Shared definitions for the single-channel byte DMA engine.
// State encoding, transfer direction constants and a small helper.
package cdma_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD_BUS = 3'd1;
  localparam logic [2:0] ST_WR_SPM = 3'd2;
  localparam logic [2:0] ST_RD_SPM = 3'd3;
  localparam logic [2:0] ST_WR_BUS = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic DIR_BUS2SPM = 1'b0;
  localparam logic DIR_SPM2BUS = 1'b1;

  // First state of every byte: the read side of the move.
  function automatic logic [2:0] first_st(input logic d);
    logic [2:0] s;
    s = ST_IDLE;
    unique case (d)
      DIR_BUS2SPM: s = ST_RD_BUS;
      DIR_SPM2BUS: s = ST_RD_SPM;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cdma_if.sv
// Control, scratchpad cDMA and Wishbone master signals of the DMA engine.
// master = engine side, slave = CPU/scratchpad/bus environment side.
interface cdma_if #(
  parameter int BUS_AWID = 16,
  parameter int SPM_AWID = 10,
  parameter int LEN_W    = 16
);

  logic                start;
  logic                dir;
  logic [BUS_AWID-1:0] bus_addr;
  logic [SPM_AWID-1:0] spm_addr;
  logic [LEN_W-1:0]    xfer_len;
  logic                abort;
  logic                busy;
  logic                done;
  logic                err;

  logic                dma_req;
  logic [SPM_AWID-1:0] dmaaddr;
  logic                we;
  logic [7:0]          spm_wdat;
  logic [7:0]          spm_rdat;

  logic [BUS_AWID-1:0] WB_ADRo;
  logic [7:0]          WB_DATo;
  logic [7:0]          WB_DATi;
  logic                WB_WEo;
  logic                WB_CYCo;
  logic                WB_STBo;
  logic                WB_ACKi;

  modport master (
    input  start, dir, bus_addr, spm_addr,
    input  xfer_len, abort,
    output busy, done, err,
    output dma_req, dmaaddr, we, spm_wdat,
    input  spm_rdat,
    output WB_ADRo, WB_DATo, WB_WEo,
    output WB_CYCo, WB_STBo,
    input  WB_DATi, WB_ACKi
  );

  modport slave (
    output start, dir, bus_addr, spm_addr,
    output xfer_len, abort,
    input  busy, done, err,
    input  dma_req, dmaaddr, we, spm_wdat,
    output spm_rdat,
    input  WB_ADRo, WB_DATo, WB_WEo,
    input  WB_CYCo, WB_STBo,
    output WB_DATi, WB_ACKi
  );

endinterface

// File: rtl/cdma_wb_timer.sv
// Wishbone ack watchdog: up-counter with clear and enable.
// expired flags the cycle whose missing ack makes TIMEOUT_CYC.
module cdma_wb_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  assign expired = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cdma_engine.sv
// Single-channel byte DMA between the Wishbone bus and the scratchpad.
// Outputs decode from state and registers only; acks steer next state.
module cdma_engine
  import cdma_pkg::*;
#(
  parameter int SPM_DEPTH   = 1024,
  parameter int SPM_AWID    = $clog2(SPM_DEPTH),
  parameter int BUS_AWID    = 16,
  parameter int LEN_W       = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input logic   clk,
  input logic   rst,
  cdma_if.master io
);

  localparam logic [SPM_AWID-1:0] SPM_LAST =
    SPM_AWID'(SPM_DEPTH - 1);

  logic [2:0]          state_q, state_d;
  logic [BUS_AWID-1:0] baddr_q, baddr_d;
  logic [SPM_AWID-1:0] saddr_q, saddr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          data_q, data_d;
  logic                dir_q, dir_d;
  logic                err_q, err_d;
  logic                ph_q, ph_d;

  logic st_bus;
  logic st_spm;
  logic wr_spm;
  logic wr_bus;
  logic active;
  logic complete;
  logic tmr_clr;
  logic tmr_en;
  logic tmr_exp;

  assign st_bus = (state_q == ST_RD_BUS) ||
                  (state_q == ST_WR_BUS);
  assign st_spm = (state_q == ST_RD_SPM) ||
                  (state_q == ST_WR_SPM);
  assign wr_spm = (state_q == ST_WR_SPM);
  assign wr_bus = (state_q == ST_WR_BUS);
  assign active = (state_q != ST_IDLE) &&
                  (state_q != ST_DONE);

  // Counter sits at zero outside bus states, so entry starts it clean.
  assign tmr_clr = !st_bus;
  assign tmr_en  = st_bus && !io.WB_ACKi;

  cdma_wb_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_exp)
  );

  always_comb begin
    state_d  = state_q;
    baddr_d  = baddr_q;
    saddr_d  = saddr_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    dir_d    = dir_q;
    err_d    = err_q;
    ph_d     = ph_q;
    complete = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (io.start) begin
          baddr_d = io.bus_addr;
          saddr_d = io.spm_addr;
          cnt_d   = io.xfer_len;
          dir_d   = io.dir;
          err_d   = 1'b0;
          if (io.xfer_len == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = first_st(io.dir);
          end
        end
      end
      ST_RD_BUS: begin
        if (io.WB_ACKi) begin
          data_d  = io.WB_DATi;
          state_d = ST_WR_SPM;
        end else if (tmr_exp) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_WR_SPM: begin
        complete = 1'b1;
      end
      ST_RD_SPM: begin
        // Phase 0 presents the address, phase 1 takes registered data.
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d    = 1'b0;
          data_d  = io.spm_rdat;
          state_d = ST_WR_BUS;
        end
      end
      ST_WR_BUS: begin
        if (io.WB_ACKi) begin
          complete = 1'b1;
        end else if (tmr_exp) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (complete) begin
      baddr_d = baddr_q + 1'b1;
      saddr_d = (saddr_q == SPM_LAST) ? '0 : saddr_q + 1'b1;
      cnt_d   = cnt_q - 1'b1;
      if (cnt_q == LEN_W'(1)) begin
        state_d = ST_DONE;
      end else begin
        state_d = first_st(dir_q);
      end
    end

    // Abort overrides the next state but keeps a completed byte.
    if (io.abort && active) begin
      state_d = ST_DONE;
      err_d   = 1'b1;
      ph_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baddr_q <= '0;
      saddr_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
      ph_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      baddr_q <= baddr_d;
      saddr_q <= saddr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
      ph_q    <= ph_d;
    end
  end

  assign io.busy     = active;
  assign io.done     = (state_q == ST_DONE);
  assign io.err      = err_q;

  assign io.dma_req  = st_spm;
  assign io.we       = wr_spm;
  assign io.dmaaddr  = st_spm ? saddr_q : '0;
  assign io.spm_wdat = wr_spm ? data_q : '0;

  assign io.WB_CYCo  = st_bus;
  assign io.WB_STBo  = st_bus;
  assign io.WB_WEo   = wr_bus;
  assign io.WB_ADRo  = st_bus ? baddr_q : '0;
  assign io.WB_DATo  = wr_bus ? data_q : '0;

endmodule

// File: tb/tb_cdma_engine.sv
// Directed bench for cdma_engine with scoreboarded SPM/WB writes.
// Slave acks one cycle after strobe; read data = addr[7:0] ^ 8'hA0.
module tb_cdma_engine;
  import cdma_pkg::*;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } exp_t;

  logic clk;
  logic rst;
  logic ack_en;
  logic pl_we;
  logic [9:0] pl_a;
  logic [7:0] pl_d;
  logic [7:0] mem [1024];

  exp_t sq[$];
  exp_t wq[$];

  int npass = 0;
  int nchk  = 0;
  int n_rd = 0, n_wbwr = 0, n_cyc = 0;
  int n_dma = 0, n_spmwr = 0, n_done = 0;

  cdma_if #(
    .BUS_AWID(16), .SPM_AWID(10), .LEN_W(16)
  ) io ();

  cdma_engine #(
    .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_we) mem[pl_a] <= pl_d;
    else if (io.dma_req && io.we)
      mem[io.dmaaddr] <= io.spm_wdat;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      io.spm_rdat <= 8'h00;
      io.WB_ACKi  <= 1'b0;
      io.WB_DATi  <= 8'h00;
    end else begin
      if (io.dma_req) io.spm_rdat <= mem[io.dmaaddr];
      io.WB_ACKi <= io.WB_CYCo && io.WB_STBo &&
                    !io.WB_ACKi && ack_en;
      io.WB_DATi <= io.WB_ADRo[7:0] ^ 8'hA0;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] expv);
    nchk++;
    assert (obs === expv) npass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, expv);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      if (io.WB_CYCo) n_cyc++;
      if (io.dma_req) n_dma++;
      if (io.done) n_done++;
      if (io.WB_CYCo && io.WB_ACKi && !io.WB_WEo) n_rd++;
      if (io.WB_CYCo && io.WB_ACKi && io.WB_WEo) begin
        n_wbwr++;
        if (wq.size() == 0) begin
          check("wb_unexpected", 32'(io.WB_ADRo), 32'hFFFF_FFFF);
        end else begin
          e = wq.pop_front();
          check("wb_addr", 32'(io.WB_ADRo), 32'(e.a));
          check("wb_data", 32'(io.WB_DATo), 32'(e.d));
        end
      end
      if (io.dma_req && io.we) begin
        n_spmwr++;
        if (sq.size() == 0) begin
          check("spm_unexpected", 32'(io.dmaaddr), 32'hFFFF_FFFF);
        end else begin
          e = sq.pop_front();
          check("spm_addr", 32'(io.dmaaddr), 32'(e.a));
          check("spm_data", 32'(io.spm_wdat), 32'(e.d));
        end
      end
    end
  end

  task automatic kick(input logic d, input logic [15:0] ba,
                      input logic [9:0] sa, input logic [15:0] ln);
    @(negedge clk);
    io.dir      = d;
    io.bus_addr = ba;
    io.spm_addr = sa;
    io.xfer_len = ln;
    io.start    = 1'b1;
    @(negedge clk);
    io.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      #1;
      if (io.done) hit = 1'b1;
    end
    check({tag, "_done"}, 32'(hit), 32'd1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_we = 1'b1;
    pl_a  = a;
    pl_d  = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_rd, b_wr, b_cyc, b_dma, b_sw, b_dn;
    bit hit;
    rst = 1'b1;
    ack_en = 1'b1;
    pl_we = 1'b0;
    pl_a = '0;
    pl_d = '0;
    io.start = 1'b0;
    io.dir = DIR_BUS2SPM;
    io.bus_addr = '0;
    io.spm_addr = '0;
    io.xfer_len = '0;
    io.abort = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", 32'({io.busy, io.done, io.err}), 32'd0);
    check("rst_spm", 32'({io.dma_req, io.we, io.dmaaddr,
                          io.spm_wdat}), 32'd0);
    check("rst_wb", 32'({io.WB_CYCo, io.WB_STBo, io.WB_WEo,
                         io.WB_ADRo, io.WB_DATo}), 32'd0);
    rst = 1'b0;

    // Bus -> SPM, 4 bytes
    for (int i = 0; i < 4; i++)
      sq.push_back('{a: 16'(10 + i), d: 8'hA0 + 8'(i)});
    b_rd = n_rd; b_wr = n_wbwr; b_dn = n_done;
    kick(DIR_BUS2SPM, 16'h0100, 10'd10, 16'd4);
    check("b2s_busy", 32'(io.busy), 32'd1);
    wait_done("b2s", 100);
    check("b2s_sb_empty", 32'(sq.size()), 32'd0);
    check("b2s_reads", 32'(n_rd - b_rd), 32'd4);
    check("b2s_wbwr", 32'(n_wbwr - b_wr), 32'd0);
    check("b2s_ndone", 32'(n_done - b_dn), 32'd1);
    check("b2s_err", 32'(io.err), 32'd0);
    check("b2s_mem13", 32'(mem[13]), 32'hA3);

    // SPM -> bus, 3 bytes
    preload(10'd0, 8'h11);
    preload(10'd1, 8'h22);
    preload(10'd2, 8'h33);
    wq.push_back('{a: 16'h0200, d: 8'h11});
    wq.push_back('{a: 16'h0201, d: 8'h22});
    wq.push_back('{a: 16'h0202, d: 8'h33});
    b_rd = n_rd; b_wr = n_wbwr; b_dma = n_dma;
    kick(DIR_SPM2BUS, 16'h0200, 10'd0, 16'd3);
    wait_done("s2b", 100);
    check("s2b_sb_empty", 32'(wq.size()), 32'd0);
    check("s2b_wbwr", 32'(n_wbwr - b_wr), 32'd3);
    check("s2b_reads", 32'(n_rd - b_rd), 32'd0);
    check("s2b_dma_cyc", 32'(n_dma - b_dma), 32'd6);
    check("s2b_err", 32'(io.err), 32'd0);

    // Zero length
    b_cyc = n_cyc; b_dma = n_dma;
    kick(DIR_BUS2SPM, 16'h0300, 10'd50, 16'd0);
    #1;
    check("z_done", 32'({io.done, io.busy}), 32'b10);
    repeat (3) @(negedge clk);
    #1;
    check("z_cyc", 32'(n_cyc - b_cyc), 32'd0);
    check("z_dma", 32'(n_dma - b_dma), 32'd0);
    check("z_err", 32'(io.err), 32'd0);

    // Timeout: slave never acks
    preload(10'd100, 8'h5A);
    ack_en = 1'b0;
    b_cyc = n_cyc; b_dn = n_done; b_sw = n_spmwr;
    kick(DIR_BUS2SPM, 16'h0300, 10'd100, 16'd2);
    wait_done("tmo", 40);
    check("tmo_cyc", 32'(n_cyc - b_cyc), 32'd8);
    check("tmo_err", 32'(io.err), 32'd1);
    check("tmo_ndone", 32'(n_done - b_dn), 32'd1);
    check("tmo_spmwr", 32'(n_spmwr - b_sw), 32'd0);
    check("tmo_mem", 32'(mem[100]), 32'h5A);
    ack_en = 1'b1;

    // SPM address wrap
    sq.push_back('{a: 16'd1023, d: 8'hA0});
    sq.push_back('{a: 16'd0, d: 8'hA1});
    kick(DIR_BUS2SPM, 16'h0400, 10'd1023, 16'd2);
    check("wrap_err_clr", 32'(io.err), 32'd0);
    wait_done("wrap", 100);
    check("wrap_sb_empty", 32'(sq.size()), 32'd0);
    check("wrap_mem", 32'({mem[1023], mem[0]}), 32'hA0A1);

    // Abort during byte 1 of 4
    sq.push_back('{a: 16'd200, d: 8'hA0});
    b_dn = n_done; b_sw = n_spmwr;
    kick(DIR_BUS2SPM, 16'h0500, 10'd200, 16'd4);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (io.WB_CYCo && (n_spmwr - b_sw) == 1) hit = 1'b1;
    end
    check("abt_reach", 32'(hit), 32'd1);
    io.abort = 1'b1;
    @(negedge clk);
    io.abort = 1'b0;
    #1;
    check("abt_drop", 32'({io.WB_CYCo, io.WB_STBo,
                           io.dma_req, io.done}), 32'b0001);
    repeat (3) @(negedge clk);
    #1;
    check("abt_err", 32'(io.err), 32'd1);
    check("abt_ndone", 32'(n_done - b_dn), 32'd1);
    check("abt_spmwr", 32'(n_spmwr - b_sw), 32'd1);
    check("abt_sb_empty", 32'(sq.size()), 32'd0);

    // Start while busy is ignored
    sq.push_back('{a: 16'd300, d: 8'hA0});
    sq.push_back('{a: 16'd301, d: 8'hA1});
    b_dn = n_done; b_wr = n_wbwr;
    kick(DIR_BUS2SPM, 16'h0600, 10'd300, 16'd2);
    @(negedge clk);
    kick(DIR_SPM2BUS, 16'h0700, 10'd500, 16'd5);
    wait_done("swb", 100);
    check("swb_sb_empty", 32'(sq.size()), 32'd0);
    check("swb_ndone", 32'(n_done - b_dn), 32'd1);
    check("swb_wbwr", 32'(n_wbwr - b_wr), 32'd0);
    check("swb_err", 32'(io.err), 32'd0);

    // Reset in the middle of WR_BUS
    b_dn = n_done;
    kick(DIR_SPM2BUS, 16'h0800, 10'd0, 16'd2);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (io.WB_WEo) hit = 1'b1;
    end
    check("rmid_reach", 32'(hit), 32'd1);
    rst = 1'b1;
    #1;
    check("rmid_drop", 32'({io.WB_CYCo, io.WB_STBo,
                            io.WB_WEo, io.busy}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rmid_nodone", 32'(n_done - b_dn), 32'd0);
    check("rmid_idle", 32'({io.busy, io.err}), 32'd0);
    check("rmid_wb_sb", 32'(wq.size()), 32'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
